// File: rtl/zetas_sram_ctrl.sv
// Zetas SRAM controller: sequences the 320-word twiddle preload, then arbitrates the single read port
// between the NTT and InvNTT fetchers (round-robin when both request, grant is combinational, data one cycle later).
module zetas_sram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int N_WORDS    = 320
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    start_i,
    input  logic                    ld_valid_i,
    output logic                    ld_ready_o,
    input  logic [DATA_WIDTH-1:0]   ld_data_i,
    output logic                    ready_o,
    input  logic [1:0]              req_i,
    input  logic [1:0]              selkd_i,
    input  logic [2*ADDR_WIDTH-1:0] addr_i,
    output logic [1:0]              gnt_o,
    output logic [1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    sram_valid_o,
    output logic                    sram_rdwen_o,
    output logic                    sram_selkd_o,
    output logic [ADDR_WIDTH-1:0]   sram_addr_o,
    output logic [DATA_WIDTH-1:0]   sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   sram_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } state_t;

    localparam logic [8:0] LAST_WORD = 9'(N_WORDS - 1);
    localparam logic [8:0] KYB_WORDS = 9'd64;

    state_t     state, state_nxt;
    logic [8:0] cnt, cnt_nxt;
    logic       rr_ptr, rr_nxt;
    logic [1:0] gnt;
    logic [1:0] rvalid_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            cnt      <= 9'd0;
            rr_ptr   <= 1'b0;
            rvalid_q <= 2'b00;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rr_ptr   <= rr_nxt;
            rvalid_q <= gnt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rr_nxt       = rr_ptr;
        gnt          = 2'b00;
        ld_ready_o   = 1'b0;
        sram_valid_o = 1'b0;
        sram_rdwen_o = 1'b0;
        sram_selkd_o = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = LOAD;
                    cnt_nxt   = 9'd0;
                end
            end
            LOAD: begin
                ld_ready_o = 1'b1;
                if (ld_valid_i) begin
                    sram_valid_o = 1'b1;
                    sram_rdwen_o = 1'b1;
                    sram_wdata_o = ld_data_i;
                    // Kyber zetas occupy the even slots of the Kyber bank; Dilithium fills its bank densely.
                    if (cnt < KYB_WORDS) begin
                        sram_selkd_o = 1'b1;
                        sram_addr_o  = ADDR_WIDTH'({cnt[5:0], 1'b0});
                    end else begin
                        sram_addr_o  = ADDR_WIDTH'(cnt - KYB_WORDS);
                    end
                    cnt_nxt = cnt + 9'd1;
                    if (cnt == LAST_WORD) begin
                        state_nxt = SERVE;
                        cnt_nxt   = 9'd0;
                    end
                end
            end
            SERVE: begin
                if (start_i) begin
                    state_nxt = LOAD;
                    cnt_nxt   = 9'd0;
                end else begin
                    if (req_i == 2'b11) gnt = rr_ptr ? 2'b10 : 2'b01;
                    else                gnt = req_i;
                    if (gnt != 2'b00) begin
                        sram_valid_o = 1'b1;
                        sram_selkd_o = gnt[1] ? selkd_i[1] : selkd_i[0];
                        sram_addr_o  = gnt[1] ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                              : addr_i[ADDR_WIDTH-1:0];
                        rr_nxt       = ~gnt[1];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt_o    = gnt;
    assign ready_o  = (state == SERVE);
    assign rvalid_o = rvalid_q;
    assign rdata_o  = (rvalid_q != 2'b00) ? sram_rdata_i : '0;

endmodule

// File: doc/zetas_sram_ctrl.md
# zetas_sram_ctrl

Controller for the twiddle-factor (zetas) SRAM. After reset it sequences a 320-word preload of the SRAM from a streaming source, then shares the single read port between two requesters: forward-NTT and inverse-NTT twiddle fetch. It sits between the NTT/InvNTT schedulers and the zetas SRAM, and owns all SRAM control signals.

## Interface
- DATA_WIDTH, 32, SRAM word width
- ADDR_WIDTH, 8, logical zeta address width (256 entries per scheme)
- N_WORDS, 320, preload length (64 Kyber + 256 Dilithium)
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- start_i  in  1  pulse: begin (re)load
- ld_valid_i  in  1  preload word valid
- ld_ready_o  out  1  preload word accepted this cycle when ld_valid_i=1
- ld_data_i  in  DATA_WIDTH  preload word
- ready_o  out  1  preload complete, read service active
- req_i  in  2  read request per port (0=NTT, 1=InvNTT)
- selkd_i  in  2  per-port scheme: 1=Kyber, 0=Dilithium
- addr_i  in  2*ADDR_WIDTH  per-port logical address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- gnt_o  out  2  one-hot grant, same cycle as request
- rvalid_o  out  2  one-hot, read data valid for port
- rdata_o  out  DATA_WIDTH  read data (shared by both ports)
- sram_valid_o  out  1  SRAM access enable
- sram_rdwen_o  out  1  1=write, 0=read
- sram_selkd_o  out  1  SRAM scheme select
- sram_addr_o  out  ADDR_WIDTH  SRAM logical address
- sram_wdata_o  out  DATA_WIDTH  SRAM write data
- sram_rdata_i  in  DATA_WIDTH  SRAM read data, valid 1 cycle after a read access

## Operation
- FSM states: IDLE, LOAD, SERVE. Reset -> IDLE.
- IDLE: ld_ready_o=0, gnt_o=0. start_i=1 -> LOAD, load counter cnt (9 bits) cleared to 0.
- LOAD: ld_ready_o=1. Each cycle with ld_valid_i=1: SRAM write of ld_data_i, cnt++.
  - cnt 0..63 (Kyber region): sram_selkd_o=1, sram_addr_o={cnt[5:0],1'b0}.
  - cnt 64..319 (Dilithium region): sram_selkd_o=0, sram_addr_o=cnt-64 (8 bits).
  - Write with cnt=N_WORDS-1 -> SERVE next cycle. ld_valid_i gaps stall the counter; no SRAM access on gap cycles.
  - start_i during LOAD: ignored.
- SERVE: ready_o=1, ld_ready_o=0.
  - Arbitration: one request granted per cycle. Single requester always granted. Both requesting: round-robin; rr_ptr (reset 0) names the preferred port, after any grant rr_ptr <= ~granted port.
  - Granted port drives sram_valid_o=1, sram_rdwen_o=0, sram_selkd_o/sram_addr_o from that port's inputs.
  - Requester holds req/selkd/addr until gnt; ungranted request is retried next cycle, no state lost.
  - start_i in SERVE: -> LOAD, cnt=0, ready_o falls next cycle; a grant in the same cycle as start_i is suppressed (start has priority).
- Idle cycles: sram_valid_o=0, sram_rdwen_o=0, sram_addr_o/wdata hold 0.

## Timing
- Reset values: ld_ready_o=0, ready_o=0, gnt_o=0, rvalid_o=0, rdata_o=0, sram_valid_o=0, sram_rdwen_o=0, sram_selkd_o=0, sram_addr_o=0, sram_wdata_o=0; rr_ptr=0, cnt=0.
- gnt_o and SRAM control are combinational from state/req_i in the grant cycle.
- Read latency: rvalid_o[p]=1 exactly 1 cycle after gnt_o[p]; rdata_o = sram_rdata_i in that cycle, else rdata_o=0.
- Throughput: 1 read/cycle sustained; 1 load word/cycle sustained; full preload ≥320 cycles.
- Last-load transition: ready_o=1 the cycle after the 320th write; first grant possible that cycle.
- Reset mid-operation: all state and outputs return to reset values immediately; a pending rvalid is dropped; SRAM contents untouched, but ready_o stays 0 until a full reload completes.

## Test plan
- Preload 320 words (value = index) back-to-back -> writes at (selkd=1, addr 0,2,…,126) then (selkd=0, addr 0..255); ready_o=1 on cycle 321 after first ld_valid.
- Preload with ld_valid_i low every other cycle -> exactly 320 writes, cnt stalls on gaps, ready_o after 640 cycles.
- SERVE, port0 only, selkd=0 addr 5 -> gnt_o=01 same cycle, rvalid_o=01 next cycle with rdata_o=sram_rdata_i.
- Both ports request continuously for 4 cycles -> grants 01,10,01,10; rvalid_o follows one cycle later each.
- Requests while IDLE/LOAD -> gnt_o=0, no SRAM reads; start_i together with req in SERVE -> no grant, LOAD entered.
- Assert rstn_i low at cnt=100 during LOAD -> all outputs zero; after start_i full 320-word reload required before ready_o=1.
